// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier producing a 2*WIDTH product from two
// WIDTH-bit operands. It handles one multiplier bit per cycle and stops early
// once no set multiplier bits remain. Signed mode multiplies the operand
// magnitudes and then negates the result when the operand signs differ.
module seq_shift_add_multiplier #(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic              SEN      = (SIGNED_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;

    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mult_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 sign_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 smode_s;
    logic                 neg_a_s;
    logic                 neg_b_s;
    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [2*WIDTH-1:0]   acc_sum_s;
    logic [WIDTH-1:0]     mult_shift_s;
    logic                 last_iter_s;
    logic [2*WIDTH-1:0]   result_s;
    logic                 busy_s;
    logic                 done_s;

    // Operand magnitudes, the partial-product step and the sign-corrected result
    always_comb begin
        smode_s = SEN & signed_mode;
        neg_a_s = smode_s & a[WIDTH-1];
        neg_b_s = smode_s & b[WIDTH-1];
        if (neg_a_s) begin
            abs_a_s = -a;
        end else begin
            abs_a_s = a;
        end
        if (neg_b_s) begin
            abs_b_s = -b;
        end else begin
            abs_b_s = b;
        end
        if (mult_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
        mult_shift_s = mult_r >> 1;
        last_iter_s  = (mult_shift_s == {WIDTH{1'b0}}) || (cnt_r == CNT_LAST);
        if (sign_r) begin
            result_s = -acc_sum_s;
        end else begin
            result_s = acc_sum_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a zero multiplier skips CALC entirely
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (abs_b_s == {WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so that busy and done can be registered
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Datapath: load operands in IDLE, iterate in CALC, write the product on the way into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mult_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sign_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r   <= {(2*WIDTH){1'b0}};
                        mcand_r <= {{WIDTH{1'b0}}, abs_a_s};
                        mult_r  <= abs_b_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        sign_r  <= neg_a_s ^ neg_b_s;
                        if (abs_b_s == {WIDTH{1'b0}}) begin
                            product_r <= {(2*WIDTH){1'b0}};
                        end
                    end
                end
                ST_CALC: begin
                    acc_r   <= acc_sum_s;
                    mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    mult_r  <= mult_shift_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        product_r <= result_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=16, signed mode enabled).
// Stimulus pushes the expected product and iteration count for each operation.
// A negedge monitor records when each start is accepted and checks product,
// latency and busy length whenever done is high.
module tb_seq_shift_add_multiplier;

    localparam int W = 16;

    typedef struct {
        string       nm;
        logic [31:0] p;
        int          k;
        bit          b2b;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            signed_mode = 1'b0;
    logic [W-1:0]    a = 16'h0000;
    logic [W-1:0]    b = 16'h0000;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];
    int   accq[$];
    int   ncyc = 0;
    int   busy_run = 0;
    int   last_done = -10;

    seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: track accepts and check every done pulse against the scoreboard
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            accq.delete();
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (expq.size() == 0 || accq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    int   t;
                    e = expq.pop_front();
                    t = accq.pop_front();
                    check({e.nm, "_product"}, product, e.p);
                    check({e.nm, "_latency"}, ncyc - t - 1, e.k);
                    check({e.nm, "_busy_len"}, busy_run, e.k + 1);
                    if (e.b2b) check({e.nm, "_b2b_gap"}, t - last_done, 1);
                end
                last_done = ncyc;
            end
            if (start && !busy) begin
                accq.push_back(ncyc);
                busy_run = 0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || expq.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic issue(input string nm, input logic sm, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [31:0] p, input int k);
        exp_t e;
        wait_idle(nm);
        e.nm = nm; e.p = p; e.k = k; e.b2b = 1'b0;
        expq.push_back(e);
        start = 1'b1; signed_mode = sm; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; signed_mode = ~sm;
    endtask

    initial begin
        exp_t e;
        int   n;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_product", product, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("u_3x5",        1'b0, 16'h0003, 16'h0005, 32'h0000000F, 3);
        issue("u_b_zero",     1'b0, 16'h1234, 16'h0000, 32'h00000000, 0);
        issue("u_ffff_sq",    1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16);
        issue("s_m3x5",       1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 3);
        issue("s_min_sq",     1'b1, 16'h8000, 16'h8000, 32'h40000000, 16);
        issue("s_max_x_min",  1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 16);
        issue("s_5xm3",       1'b1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1, 2);
        issue("u_fffd_x5",    1'b0, 16'hFFFD, 16'h0005, 32'h0004FFF1, 3);
        issue("s_zero_xm1",   1'b1, 16'h0000, 16'hFFFF, 32'h00000000, 1);
        issue("s_m1xm1",      1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1);

        // start pulsed mid-CALC with different operands must be ignored
        issue("u_ignore",     1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 9);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;

        // start held high: second op accepted in the IDLE cycle after DONE
        wait_idle("hold_pre");
        e.nm = "u_hold1"; e.p = 32'h0000000E; e.k = 3; e.b2b = 1'b0;
        expq.push_back(e);
        e.nm = "u_hold2"; e.p = 32'h00000030; e.k = 2; e.b2b = 1'b1;
        expq.push_back(e);
        start = 1'b1; signed_mode = 1'b0; a = 16'h0002; b = 16'h0007;
        @(posedge clk); #1;
        a = 16'h0010; b = 16'h0003;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("hold_done_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("hold_post");

        // asynchronous reset mid-CALC clears outputs at once and drops the op
        issue("u_aborted",    1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_product", product, 32'h0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        issue("u_after_rst",  1'b0, 16'h0003, 16'h0005, 32'h0000000F, 3);
        wait_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
